// File: rtl/q_sys_led_pkg.sv
// Shared encodings for the LED PIO arbiter: requester ops, PIO register map and FSM states.
package q_sys_led_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLR   = 2'b10,
    OP_NOP   = 2'b11
  } op_t;

  localparam logic [2:0] PIO_DATA = 3'd0;
  localparam logic [2:0] PIO_SET  = 3'd4;
  localparam logic [2:0] PIO_CLR  = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  function automatic logic [2:0] op_addr(input op_t op);
    logic [2:0] a;
    case (op)
      OP_SET:  a = PIO_SET;
      OP_CLR:  a = PIO_CLR;
      default: a = PIO_DATA;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/q_sys_led_pio_arbiter_rr.sv
// Combinational round-robin pick: first set req bit scanning upward from ptr+1, wrapping at NREQ.
module rr_arbiter_comb #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  int unsigned idx;

  // Walk offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int unsigned off = NREQ; off > 0; off--) begin
      idx = (32'(ptr) + off) % NREQ;
      if (req[IDX_W'(idx)]) begin
        winner = IDX_W'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/q_sys_led_pio_arbiter.sv
// Round-robin sharing of the LED PIO s1 port; one Avalon-MM write per grant, shadowed LED state.
module q_sys_led_pio_arbiter
  import q_sys_led_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned LED_W  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [LED_W*NREQ-1:0] req_mask,
  output logic [NREQ-1:0]       ack,
  output logic [ADDR_W-1:0]     m_address,
  output logic                  m_chipselect,
  output logic                  m_write_n,
  output logic [31:0]           m_writedata,
  input  logic                  m_waitrequest,
  output logic [LED_W-1:0]      led_shadow,
  output logic                  busy
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  win_q, win_d;
  op_t               op_q, op_d;
  logic [LED_W-1:0]  mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cs_q, cs_d;
  logic              wr_n_q, wr_n_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [LED_W-1:0]  shadow_q, shadow_d;
  logic [NREQ-1:0]   ack_q, ack_d;

  logic [IDX_W-1:0]  arb_winner;
  logic              arb_valid;
  logic [1:0]        sel_op;
  logic [LED_W-1:0]  sel_mask;

  rr_arbiter_comb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req    (req),
    .ptr    (ptr_q),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  always_comb begin
    sel_op   = '0;
    sel_mask = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == arb_winner) begin
        sel_op   = req_op[2*i +: 2];
        sel_mask = req_mask[LED_W*i +: LED_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    op_d     = op_q;
    mask_d   = mask_q;
    addr_d   = addr_q;
    cs_d     = cs_q;
    wr_n_d   = wr_n_q;
    wdata_d  = wdata_q;
    shadow_d = shadow_q;
    ack_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          win_d  = arb_winner;
          ptr_d  = arb_winner;
          op_d   = op_t'(sel_op);
          mask_d = sel_mask;
          if (op_t'(sel_op) == OP_NOP) begin
            state_d            = DONE;
            ack_d[arb_winner]  = 1'b1;
          end else begin
            state_d              = WRITE;
            cs_d                 = 1'b1;
            wr_n_d               = 1'b0;
            addr_d               = ADDR_W'(op_addr(op_t'(sel_op)));
            wdata_d              = '0;
            wdata_d[LED_W-1:0]   = sel_mask;
          end
        end
      end
      // Bus registers simply hold while the fabric stalls.
      WRITE: begin
        if (!m_waitrequest) begin
          state_d       = DONE;
          cs_d          = 1'b0;
          wr_n_d        = 1'b1;
          addr_d        = '0;
          wdata_d       = '0;
          ack_d[win_q]  = 1'b1;
          case (op_q)
            OP_WRITE: shadow_d = mask_q;
            OP_SET:   shadow_d = shadow_q | mask_q;
            OP_CLR:   shadow_d = shadow_q & ~mask_q;
            default:  shadow_d = shadow_q;
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= IDX_W'(NREQ - 1);
      win_q    <= '0;
      op_q     <= OP_WRITE;
      mask_q   <= '0;
      addr_q   <= '0;
      cs_q     <= 1'b0;
      wr_n_q   <= 1'b1;
      wdata_q  <= '0;
      shadow_q <= '0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      op_q     <= op_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      cs_q     <= cs_d;
      wr_n_q   <= wr_n_d;
      wdata_q  <= wdata_d;
      shadow_q <= shadow_d;
      ack_q    <= ack_d;
    end
  end

  assign ack          = ack_q;
  assign m_address    = addr_q;
  assign m_chipselect = cs_q;
  assign m_write_n    = wr_n_q;
  assign m_writedata  = wdata_q;
  assign led_shadow   = shadow_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_q_sys_led_pio_arbiter.sv
// Directed bench for the LED PIO arbiter with a stall-programmable PIO model.
module tb_q_sys_led_pio_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [31:0] req_mask;
  logic [3:0]  ack;
  logic [2:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic [7:0]  led_shadow;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int stall_cfg = 0;

  always #5 clk = ~clk;

  q_sys_led_pio_arbiter #(
    .NREQ   (4),
    .LED_W  (8),
    .ADDR_W (3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .req_op        (req_op),
    .req_mask      (req_mask),
    .ack           (ack),
    .m_address     (m_address),
    .m_chipselect  (m_chipselect),
    .m_write_n     (m_write_n),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .led_shadow    (led_shadow),
    .busy          (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // PIO model: holds waitrequest for stall_cfg cycles of each access.
  initial begin
    int cnt;
    cnt = 0;
    m_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      if (m_chipselect && !m_write_n) begin
        if (cnt < stall_cfg) begin
          m_waitrequest = 1'b1;
          cnt++;
        end else begin
          m_waitrequest = 1'b0;
        end
      end else begin
        m_waitrequest = 1'b0;
        cnt = 0;
      end
    end
  end

  typedef struct {
    int         r;
    logic [1:0] op;
    logic [7:0] mask;
    int         stall;
    logic [2:0] e_addr;
    logic [7:0] e_shadow;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input int i, input vec_t v, input logic [7:0] prev_shadow);
    int n, wc, lat, e_lat, e_wc;
    logic [3:0]  ack_seen;
    logic [2:0]  a0;
    logic [31:0] d0;
    logic [7:0]  sh;
    logic stable, early_ok;
    n = 0; wc = 0; lat = -1; ack_seen = '0; a0 = '0; d0 = '0; sh = '0;
    stable = 1'b1; early_ok = 1'b1;
    stall_cfg = v.stall;
    @(negedge clk);
    req = '0;
    req[v.r] = 1'b1;
    req_op[2*v.r +: 2]   = v.op;
    req_mask[8*v.r +: 8] = v.mask;
    while (lat < 0 && n < 40) begin
      @(negedge clk);
      n++;
      req_op[2*v.r +: 2]   = ~v.op;
      req_mask[8*v.r +: 8] = ~v.mask;
      if (m_chipselect) begin
        if (wc == 0) begin
          a0 = m_address;
          d0 = m_writedata;
        end else if (m_address !== a0 || m_writedata !== d0) begin
          stable = 1'b0;
        end
        if (m_write_n !== 1'b0) stable = 1'b0;
        if (led_shadow !== prev_shadow) early_ok = 1'b0;
        wc++;
      end
      if (ack != 0) begin
        ack_seen = ack;
        lat = n;
        sh = led_shadow;
      end
    end
    req = '0;
    e_lat = (v.op == 2'b11) ? 1 : 2 + v.stall;
    e_wc  = (v.op == 2'b11) ? 0 : 1 + v.stall;
    check($sformatf("v%0d ack", i), 32'(ack_seen), 32'(4'b0001 << v.r));
    check($sformatf("v%0d latency", i), lat, e_lat);
    check($sformatf("v%0d bus_cycles", i), wc, e_wc);
    check($sformatf("v%0d shadow", i), 32'(sh), 32'(v.e_shadow));
    check($sformatf("v%0d early_shadow", i), 32'(early_ok), 32'd1);
    if (e_wc > 0) begin
      check($sformatf("v%0d addr", i), 32'(a0), 32'(v.e_addr));
      check($sformatf("v%0d data", i), d0, {24'h0, v.mask});
      check($sformatf("v%0d stable", i), 32'(stable), 32'd1);
    end
  endtask

  initial begin
    int n, k, last;
    logic idle_seen;
    int exp_order[5];
    logic [3:0] any_ack;

    exp_order = '{0, 1, 2, 3, 0};
    //          r  op     mask   stall addr  shadow
    vecs[0] = '{0, 2'b00, 8'hA5, 0,    3'd0, 8'hA5};
    vecs[1] = '{1, 2'b01, 8'h0F, 0,    3'd4, 8'hAF};
    vecs[2] = '{2, 2'b10, 8'h81, 0,    3'd5, 8'h2E};
    vecs[3] = '{0, 2'b00, 8'h3C, 3,    3'd0, 8'h3C};
    vecs[4] = '{2, 2'b11, 8'hFF, 0,    3'd0, 8'h3C};
    vecs[5] = '{3, 2'b01, 8'h00, 0,    3'd4, 8'h3C};
    vecs[6] = '{1, 2'b10, 8'h00, 0,    3'd5, 8'h3C};
    vecs[7] = '{3, 2'b01, 8'hF0, 1,    3'd4, 8'hFC};

    reset_n = 1'b0;
    req = '0;
    req_op = '1;
    req_mask = '0;
    repeat (2) @(negedge clk);
    check("rst ack", 32'(ack), 32'd0);
    check("rst cs", 32'(m_chipselect), 32'd0);
    check("rst write_n", 32'(m_write_n), 32'd1);
    check("rst addr", 32'(m_address), 32'd0);
    check("rst data", m_writedata, 32'd0);
    check("rst shadow", 32'(led_shadow), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i], (i == 0) ? 8'h00 : vecs[i-1].e_shadow);
    end

    // Reset in the middle of a stalled write.
    stall_cfg = 5;
    @(negedge clk);
    req = 4'b0010;
    req_op[3:2] = 2'b00;
    req_mask[15:8] = 8'h77;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_chipselect && n < 20);
    check("midrst in_write", 32'(m_chipselect), 32'd1);
    reset_n = 1'b0;
    req = '0;
    #1;
    check("midrst cs", 32'(m_chipselect), 32'd0);
    check("midrst write_n", 32'(m_write_n), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst shadow", 32'(led_shadow), 32'd0);
    any_ack = '0;
    repeat (3) begin
      @(negedge clk);
      any_ack |= ack;
    end
    check("midrst no_ack", 32'(any_ack), 32'd0);
    stall_cfg = 0;
    reset_n = 1'b1;

    // All four requesters held high across five grants.
    @(negedge clk);
    req_op = 8'h00;
    req_mask = {8'h08, 8'h04, 8'h02, 8'h01};
    req = 4'b1111;
    n = 0; k = 0; last = 0; idle_seen = 1'b0;
    while (k < 5 && n < 60) begin
      @(negedge clk);
      n++;
      if (!busy) idle_seen = 1'b1;
      if (ack != 0) begin
        check($sformatf("rr ack%0d", k), 32'(ack), 32'(4'b0001 << exp_order[k]));
        if (k == 0) check("rr first_latency", n, 2);
        else begin
          check($sformatf("rr gap%0d", k), n - last, 3);
          check($sformatf("rr idle%0d", k), 32'(idle_seen), 32'd1);
        end
        last = n;
        idle_seen = 1'b0;
        k++;
      end
    end
    req = '0;
    check("rr grants", k, 5);
    check("rr shadow", 32'(led_shadow), 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
